// File: rtl/du_register_way0.sv
// Way-0 decode-to-execute pipeline register: main + skid entry, registered ready_o, flush, saturating stall counter.
// Optional macro DU_REG_INSTADDR_EN carries a 32-bit instruction address alongside the bundle.
module du_register_way0 #(
    parameter int DATA_W = 64,
    parameter int PID_W  = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [4:0]        rdAddr_i,
    input  logic              rdWriteEnable_i,
    input  logic [DATA_W-1:0] rs1ReadData_i,
    input  logic [DATA_W-1:0] rs2ReadData_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [6:0]        opCode_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [5:0]        shamt_i,
    input  logic [PID_W-1:0]  pID_i,
`ifdef DU_REG_INSTADDR_EN
    input  logic [31:0]       instAddr_i,
    output logic [31:0]       instAddr_o,
`endif
    output logic              valid_o,
    input  logic              ready_i,
    output logic [4:0]        rdAddr_o,
    output logic              rdWriteEnable_o,
    output logic [DATA_W-1:0] rs1ReadData_o,
    output logic [DATA_W-1:0] rs2ReadData_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [6:0]        opCode_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output logic [5:0]        shamt_o,
    output logic [PID_W-1:0]  pID_o,
    output logic [CNT_W-1:0]  stallCount_o
);

    localparam int BASE_W = 5 + 1 + 3 * DATA_W + 7 + 3 + 7 + 6 + PID_W;
`ifdef DU_REG_INSTADDR_EN
    localparam int BUN_W = BASE_W + 32;
`else
    localparam int BUN_W = BASE_W;
`endif

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [BUN_W-1:0]   r_main;
    logic [BUN_W-1:0]   r_skid;
    logic               r_valid_o;
    logic               r_ready_o;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic [BUN_W-1:0]   w_in_bundle;
    logic               w_accept;
    logic               w_transfer;
    logic               w_load_main_in;
    logic               w_load_main_skid;
    logic               w_load_skid;
    logic               w_stall;

`ifdef DU_REG_INSTADDR_EN
    assign w_in_bundle = {instAddr_i, rdAddr_i, rdWriteEnable_i, rs1ReadData_i, rs2ReadData_i,
                          imm_i, opCode_i, funct3_i, funct7_i, shamt_i, pID_i};
    assign instAddr_o  = r_main[BUN_W-1:BASE_W];
`else
    assign w_in_bundle = {rdAddr_i, rdWriteEnable_i, rs1ReadData_i, rs2ReadData_i,
                          imm_i, opCode_i, funct3_i, funct7_i, shamt_i, pID_i};
`endif

    assign {rdAddr_o, rdWriteEnable_o, rs1ReadData_o, rs2ReadData_o, imm_o,
            opCode_o, funct3_o, funct7_o, shamt_o, pID_o} = r_main[BASE_W-1:0];

    assign valid_o      = r_valid_o;
    assign ready_o      = r_ready_o;
    assign stallCount_o = r_stall_cnt;

    assign w_accept   = valid_i && r_ready_o;
    assign w_transfer = r_valid_o && ready_i;
    assign w_stall    = r_valid_o && !ready_i;

    // Flush overrides every handshake: no register loads, state collapses to EMPTY.
    always_comb begin
        w_state_next     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush_i) begin
            w_state_next = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_load_main_in = 1'b1;
                        w_state_next   = S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_transfer) begin
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_load_skid  = 1'b1;
                        w_state_next = S_FULL;
                    end else if (w_transfer) begin
                        w_state_next = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_transfer) begin
                        w_load_main_skid = 1'b1;
                        w_state_next     = S_ONE;
                    end
                end
                default: begin
                    w_state_next = S_EMPTY;
                end
            endcase
        end
    end

    // Handshake outputs are decoded from the next state so both are plain flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_EMPTY;
            r_valid_o <= 1'b0;
            r_ready_o <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_valid_o <= (w_state_next != S_EMPTY);
            r_ready_o <= (w_state_next != S_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= w_in_bundle;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in_bundle;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_du_register_way0.sv
// Directed bench for du_register_way0: vector table plus hand-written reset, stall-saturation and instAddr sequences.
module tb_du_register_way0;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [4:0]  rdAddr_i;
    logic        rdWriteEnable_i;
    logic [63:0] rs1ReadData_i;
    logic [63:0] rs2ReadData_i;
    logic [63:0] imm_i;
    logic [6:0]  opCode_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [5:0]  shamt_i;
    logic [1:0]  pID_i;
    logic        valid_o;
    logic        ready_i;
    logic [4:0]  rdAddr_o;
    logic        rdWriteEnable_o;
    logic [63:0] rs1ReadData_o;
    logic [63:0] rs2ReadData_o;
    logic [63:0] imm_o;
    logic [6:0]  opCode_o;
    logic [2:0]  funct3_o;
    logic [6:0]  funct7_o;
    logic [5:0]  shamt_o;
    logic [1:0]  pID_o;
    logic [31:0] stallCount_o;
`ifdef DU_REG_INSTADDR_EN
    logic [31:0] instAddr_i;
    logic [31:0] instAddr_o;
    logic [31:0] s_instAddr_o;
`endif

    // Second instance with a 2-bit counter so saturation is reachable in a few cycles.
    logic        s_ready_o;
    logic        s_valid_o;
    logic [4:0]  s_rdAddr_o;
    logic        s_rdWriteEnable_o;
    logic [63:0] s_rs1ReadData_o;
    logic [63:0] s_rs2ReadData_o;
    logic [63:0] s_imm_o;
    logic [6:0]  s_opCode_o;
    logic [2:0]  s_funct3_o;
    logic [6:0]  s_funct7_o;
    logic [5:0]  s_shamt_o;
    logic [1:0]  s_pID_o;
    logic [1:0]  s_stallCount_o;

    int n_cmp;
    int n_fail;

    du_register_way0 #(.DATA_W(64), .PID_W(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .rdAddr_i(rdAddr_i), .rdWriteEnable_i(rdWriteEnable_i), .rs1ReadData_i(rs1ReadData_i),
        .rs2ReadData_i(rs2ReadData_i), .imm_i(imm_i), .opCode_i(opCode_i), .funct3_i(funct3_i),
        .funct7_i(funct7_i), .shamt_i(shamt_i), .pID_i(pID_i),
`ifdef DU_REG_INSTADDR_EN
        .instAddr_i(instAddr_i), .instAddr_o(instAddr_o),
`endif
        .valid_o(valid_o), .ready_i(ready_i), .rdAddr_o(rdAddr_o), .rdWriteEnable_o(rdWriteEnable_o),
        .rs1ReadData_o(rs1ReadData_o), .rs2ReadData_o(rs2ReadData_o), .imm_o(imm_o),
        .opCode_o(opCode_o), .funct3_o(funct3_o), .funct7_o(funct7_o), .shamt_o(shamt_o),
        .pID_o(pID_o), .stallCount_o(stallCount_o)
    );

    du_register_way0 #(.DATA_W(64), .PID_W(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(s_ready_o),
        .rdAddr_i(rdAddr_i), .rdWriteEnable_i(rdWriteEnable_i), .rs1ReadData_i(rs1ReadData_i),
        .rs2ReadData_i(rs2ReadData_i), .imm_i(imm_i), .opCode_i(opCode_i), .funct3_i(funct3_i),
        .funct7_i(funct7_i), .shamt_i(shamt_i), .pID_i(pID_i),
`ifdef DU_REG_INSTADDR_EN
        .instAddr_i(instAddr_i), .instAddr_o(s_instAddr_o),
`endif
        .valid_o(s_valid_o), .ready_i(ready_i), .rdAddr_o(s_rdAddr_o), .rdWriteEnable_o(s_rdWriteEnable_o),
        .rs1ReadData_o(s_rs1ReadData_o), .rs2ReadData_o(s_rs2ReadData_o), .imm_o(s_imm_o),
        .opCode_o(s_opCode_o), .funct3_o(s_funct3_o), .funct7_o(s_funct7_o), .shamt_o(s_shamt_o),
        .pID_o(s_pID_o), .stallCount_o(s_stallCount_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    // Reference payload for a tag: every field derived independently from the tag byte.
    function automatic logic [255:0] exp_payload(input logic [7:0] t);
        logic [255:0] r;
        r = '0;
        r[222:0] = {t[4:0], t[0], {8{t}}, ~{8{t}}, {t, 48'h0, t}, t[6:0], t[2:0] ^ 3'b101,
                    ~t[6:0], t[5:0], t[1:0]};
        return r;
    endfunction

    function automatic logic [255:0] act_payload();
        logic [255:0] r;
        r = '0;
        r[222:0] = {rdAddr_o, rdWriteEnable_o, rs1ReadData_o, rs2ReadData_o, imm_o, opCode_o,
                    funct3_o, funct7_o, shamt_o, pID_o};
        return r;
    endfunction

    task automatic drive_tag(input logic [7:0] t);
        rdAddr_i        = t[4:0];
        rdWriteEnable_i = t[0];
        rs1ReadData_i   = {8{t}};
        rs2ReadData_i   = ~{8{t}};
        imm_i           = {t, 48'h0, t};
        opCode_i        = t[6:0];
        funct3_i        = t[2:0] ^ 3'b101;
        funct7_i        = ~t[6:0];
        shamt_i         = t[5:0];
        pID_i           = t[1:0];
`ifdef DU_REG_INSTADDR_EN
        instAddr_i      = {24'h800000, t};
`endif
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        flush;
        logic        valid;
        logic [7:0]  tag;
        logic        rdy;
        logic        e_valid;
        logic        e_ready;
        logic [7:0]  e_tag;
        logic [31:0] e_stall;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input logic f, input logic v, input logic [7:0] t, input logic r,
                                input logic ev, input logic er, input logic [7:0] et,
                                input logic [31:0] es);
        vec_t x;
        x.flush = f; x.valid = v; x.tag = t; x.rdy = r;
        x.e_valid = ev; x.e_ready = er; x.e_tag = et; x.e_stall = es;
        return x;
    endfunction

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        drive_tag(8'h00);

        // Back-to-back stream of 8, stall with skid, flush in FULL and ONE.
        for (int i = 0; i < 8; i++)
            vecs[i] = mk(0, 1, 8'h10 + 8'(i), 1, 1, 1, 8'h10 + 8'(i), 0);
        vecs[8]  = mk(0, 0, 8'h00, 1, 0, 1, 8'h00, 0);
        vecs[9]  = mk(0, 1, 8'h2A, 0, 1, 1, 8'h2A, 0);
        vecs[10] = mk(0, 1, 8'h3B, 0, 1, 0, 8'h2A, 1);
        vecs[11] = mk(0, 1, 8'h4C, 0, 1, 0, 8'h2A, 2);
        vecs[12] = mk(0, 0, 8'h00, 0, 1, 0, 8'h2A, 3);
        vecs[13] = mk(0, 0, 8'h00, 1, 1, 1, 8'h3B, 3);
        vecs[14] = mk(0, 0, 8'h00, 1, 0, 1, 8'h00, 3);
        vecs[15] = mk(0, 1, 8'h51, 0, 1, 1, 8'h51, 3);
        vecs[16] = mk(0, 1, 8'h52, 0, 1, 0, 8'h51, 4);
        vecs[17] = mk(1, 1, 8'h53, 0, 0, 1, 8'h00, 5);
        vecs[18] = mk(0, 0, 8'h00, 1, 0, 1, 8'h00, 5);
        vecs[19] = mk(0, 1, 8'h61, 1, 1, 1, 8'h61, 5);
        vecs[20] = mk(1, 1, 8'h62, 1, 0, 1, 8'h00, 5);
        vecs[21] = mk(0, 1, 8'h63, 1, 1, 1, 8'h63, 5);
        vecs[22] = mk(0, 0, 8'h00, 0, 1, 1, 8'h63, 6);
        vecs[23] = mk(0, 0, 8'h00, 1, 0, 1, 8'h00, 6);

        tick(); tick();
        check("reset_valid_o", 256'(valid_o), 256'(1'b0));
        check("reset_ready_o", 256'(ready_o), 256'(1'b1));
        check("reset_stall",   256'(stallCount_o), 256'(0));
        check("reset_payload", act_payload(), exp_payload(8'h00) & 256'h0);
        $display("txn reset: valid_o=%0b ready_o=%0b stall=%0d", valid_o, ready_o, stallCount_o);
        rst = 1'b1;

        // Single bundle with the named field values.
        drive_tag(8'h00);
        opCode_i = 7'b0010011; imm_i = 64'h5; rdAddr_i = 5'd3; pID_i = 2'd1;
        valid_i = 1'b1; ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        check("single_valid", 256'(valid_o), 256'(1'b1));
        check("single_fields", 256'({opCode_o, imm_o, rdAddr_o, pID_o}),
              256'({7'b0010011, 64'h5, 5'd3, 2'd1}));
        $display("txn single: valid_o=%0b opCode=%0h imm=%0h rd=%0d pID=%0d",
                 valid_o, opCode_o, imm_o, rdAddr_o, pID_o);
        tick();
        check("single_drop", 256'(valid_o), 256'(1'b0));

        for (int i = 0; i < 24; i++) begin
            flush_i = vecs[i].flush;
            valid_i = vecs[i].valid;
            ready_i = vecs[i].rdy;
            drive_tag(vecs[i].tag);
            tick();
            check($sformatf("vec%0d_valid_o", i), 256'(valid_o), 256'(vecs[i].e_valid));
            check($sformatf("vec%0d_ready_o", i), 256'(ready_o), 256'(vecs[i].e_ready));
            check($sformatf("vec%0d_stall", i), 256'(stallCount_o), 256'(vecs[i].e_stall));
            if (vecs[i].e_valid)
                check($sformatf("vec%0d_payload", i), act_payload(), exp_payload(vecs[i].e_tag));
            $display("txn vec%0d: flush=%0b valid_i=%0b tag=%0h ready_i=%0b -> valid_o=%0b ready_o=%0b opCode=%0h stall=%0d",
                     i, vecs[i].flush, vecs[i].valid, vecs[i].tag, vecs[i].rdy,
                     valid_o, ready_o, opCode_o, stallCount_o);
        end
        flush_i = 1'b0;

        // Fill to FULL, then pulse reset between edges: values return immediately.
        valid_i = 1'b1; ready_i = 1'b0; drive_tag(8'h71); tick();
        drive_tag(8'h72); tick();
        valid_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("midreset_valid_o", 256'(valid_o), 256'(1'b0));
        check("midreset_ready_o", 256'(ready_o), 256'(1'b1));
        check("midreset_stall",   256'(stallCount_o), 256'(0));
        check("midreset_payload", act_payload(), 256'(0));
        $display("txn midreset: valid_o=%0b ready_o=%0b stall=%0d", valid_o, ready_o, stallCount_o);
        tick();
        rst = 1'b1;

        // Saturation: the 2-bit counter must stop at 3 while the 32-bit one keeps counting.
        valid_i = 1'b1; ready_i = 1'b0; drive_tag(8'h81); tick();
        valid_i = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check($sformatf("sat_cnt%0d", c), 256'(s_stallCount_o), 256'((c > 3) ? 3 : c));
            check($sformatf("wide_cnt%0d", c), 256'(stallCount_o), 256'(c));
            check($sformatf("sat_hold%0d", c), act_payload(), exp_payload(8'h81));
            $display("txn sat%0d: stall2=%0d stall32=%0d", c, s_stallCount_o, stallCount_o);
        end
        ready_i = 1'b1; tick();
        check("sat_drain_valid", 256'(valid_o), 256'(1'b0));

`ifdef DU_REG_INSTADDR_EN
        // instAddr follows B out of the skid entry.
        valid_i = 1'b1; ready_i = 1'b0; drive_tag(8'h91); instAddr_i = 32'h8000_0000; tick();
        drive_tag(8'h92); instAddr_i = 32'h8000_0004; tick();
        valid_i = 1'b0;
        check("ia_A", 256'(instAddr_o), 256'(32'h8000_0000));
        ready_i = 1'b1; tick();
        check("ia_B", 256'(instAddr_o), 256'(32'h8000_0004));
        check("ia_B_payload", act_payload(), exp_payload(8'h92));
        $display("txn instaddr: instAddr_o=%0h opCode=%0h", instAddr_o, opCode_o);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/du_register_way0.md
Name: du_register_way0

Overview:
- Way-0 pipeline register between the way-0 decoder and the execute stage.
- Captures the decoded instruction bundle under a valid/ready handshake.
- A two-entry skid buffer gives full throughput with a fully registered ready_o.
- Supports a pipeline flush and provides a saturating back-pressure (stall) counter.

Parameters:
- DATA_W, 64, width of rs1/rs2 data and imm
- PID_W, 2, width of the packet ID
- CNT_W, 32, width of the stall counter

Ports:
- clk  in  1  core clock, all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous flush; drops every held and incoming entry
- valid_i  in  1  upstream bundle valid (from decoder valid_o)
- ready_o  out  1  to decoder ready_i; registered
- rdAddr_i  in  5  decoded rd address
- rdWriteEnable_i  in  1  rd write enable
- rs1ReadData_i  in  DATA_W  rs1 operand
- rs2ReadData_i  in  DATA_W  rs2 operand
- imm_i  in  DATA_W  sign-extended immediate
- opCode_i  in  7  opcode
- funct3_i  in  3  funct3
- funct7_i  in  7  funct7
- shamt_i  in  6  shift amount
- pID_i  in  PID_W  packet ID
- valid_o  out  1  bundle valid to execute
- ready_i  in  1  execute can accept
- rdAddr_o, rdWriteEnable_o, rs1ReadData_o, rs2ReadData_o, imm_o, opCode_o, funct3_o, funct7_o, shamt_o, pID_o  out  same widths as inputs  held bundle
- stallCount_o  out  CNT_W  cycles with valid_o=1 and ready_i=0

Behaviour:
- Reset (rst=0, async):
  - state=EMPTY, valid_o=0, ready_o=1, stallCount_o=0.
  - Every payload output reads 0.
- Storage: main register (drives outputs) plus one skid register; payload is carried bit-exact, no arithmetic.
- Handshakes:
  - Upstream accept: valid_i && ready_o.
  - Downstream transfer: valid_o && ready_i.
- States:
  - EMPTY: valid_o=0, ready_o=1. Accept loads main -> ONE.
  - ONE: valid_o=1, ready_o=1.
    - Accept and transfer together: main reloads -> ONE.
    - Accept only: incoming goes to skid -> FULL.
    - Transfer only -> EMPTY.
  - FULL: valid_o=1, ready_o=0.
    - Transfer: skid moves to main -> ONE.
    - Otherwise hold.
- Ordering: strict FIFO; main is always older than skid.
- Latency:
  - 1 cycle from accept to valid_o in EMPTY.
  - Throughput is 1 bundle/cycle when ready_i stays high.
- ready_o is a flop output; it is never combinationally dependent on ready_i.
- Output stability: payload outputs must not change while valid_o=1 && ready_i=0.
- flush_i=1:
  - Next edge: state=EMPTY, valid_o=0, ready_o=1.
  - Any simultaneous accept is discarded.
  - Payload registers may keep stale data but valid_o=0.
  - Flush has priority over every other event.
- Stall counter:
  - Increments by 1 each cycle valid_o && !ready_i.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Unaffected by flush_i; cleared only by reset.
- Reset asserted mid-operation: immediate return to reset values; in-flight bundles are lost.

Optional Feature:
- Macro DU_REG_INSTADDR_EN.
- Defined:
  - Adds ports instAddr_i in 32 and instAddr_o out 32.
  - instAddr travels through main/skid with the bundle, same ordering and flush rules; reset value 0.
- Undefined:
  - Ports are absent; no storage is added; all other behaviour is identical.

Test Plan:
- Reset then single bundle (opCode_i=7'b0010011, imm_i=64'h5, rdAddr_i=3, pID_i=1), ready_i=1 -> valid_o=1 exactly one cycle later with the same fields; next cycle valid_o=0.
- Stream 8 bundles back-to-back, ready_i=1 -> 8 consecutive valid_o cycles in order; ready_o stays 1.
- ready_i=0 with bundles A,B offered -> A in main, B in skid, ready_o=0. Outputs hold A. stallCount_o increments each cycle. Releasing ready_i delivers A then B.
- FULL state plus flush_i=1 with valid_i=1 -> next cycle valid_o=0 and ready_o=1; the incoming bundle is never output.
- Force the counter to 32'hFFFF_FFFE and hold the stall 3 cycles -> stallCount_o=32'hFFFF_FFFF, no wrap.
- With DU_REG_INSTADDR_EN: instAddr_i=32'h8000_0004 on bundle B behind a stalled A -> instAddr_o=32'h8000_0004 appears together with B's fields.
